// File: rtl/l2_cache_nway_if.sv
// Bus bundle between the L1/arbiter side, the N-way L2 and the cacheline adapter.
// slave is the cache's view; master is the view of the requester plus memory model around it.
interface l2_cache_nway_if;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_byte_enable;
  logic         mem_resp;
  logic [255:0] mem_rdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata,
    input  pmem_resp, pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata,
    output pmem_resp, pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/l2_cache_nway.sv
// Write-back, write-allocate, N-way set-associative line cache with tree pseudo-LRU.
//   state | meaning
//   IDLE  | waiting for a read or write request
//   CHECK | tag compare; hit responds, miss picks and latches a victim
//   WB    | writing the dirty victim line back to memory
//   FILL  | fetching the requested line into the victim way
module l2_cache_nway #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input logic            clk,
  input logic            rst,
  l2_cache_nway_if.slave bus
);
  localparam int num_sets   = 2 ** s_index;
  localparam int s_way      = $clog2(num_ways);
  localparam int line_bytes = 2 ** s_offset;

  typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;
  state_t state, state_next;

  logic [255:0]        data_arr  [num_sets][num_ways];
  logic [s_tag-1:0]    tag_arr   [num_sets][num_ways];
  logic [num_ways-1:0] valid_arr [num_sets];
  logic [num_ways-1:0] dirty_arr [num_sets];
  logic [num_ways-2:0] plru_arr  [num_sets];

  logic [s_index-1:0] idx;
  logic [s_tag-1:0]   tag;
  logic               req, wr, hit, inv_found;
  logic [s_way-1:0]   hit_way, inv_way, plru_way, victim_sel, victim_q;
  logic               unused_offset;
  int                 walk_node;

  assign idx           = bus.mem_address[s_offset +: s_index];
  assign tag           = bus.mem_address[31 -: s_tag];
  assign req           = bus.mem_read | bus.mem_write;
  assign wr            = bus.mem_write;
  assign unused_offset = ^bus.mem_address[s_offset-1:0];

  function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] p,
                                                      input logic [s_way-1:0] w);
    logic [num_ways-2:0] r;
    int node;
    r = p;
    node = 0;
    for (int l = 0; l < s_way; l++) begin
      r[node] = ~w[s_way-1-l];
      node = 2 * node + 1 + int'(w[s_way-1-l]);
    end
    return r;
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] wd,
                                         input logic [31:0] be);
    logic [255:0] r;
    for (int i = 0; i < line_bytes; i++)
      r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv_found = 1'b0;
    inv_way = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (valid_arr[idx][w] && tag_arr[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = s_way'(w);
      end
      if (!valid_arr[idx][w]) begin
        inv_found = 1'b1;
        inv_way = s_way'(w);
      end
    end
  end

  // Tree nodes are stored heap-style: children of node n are 2n+1 (left) and 2n+2 (right).
  always_comb begin
    plru_way = '0;
    walk_node = 0;
    for (int l = 0; l < s_way; l++) begin
      plru_way[s_way-1-l] = plru_arr[idx][walk_node];
      walk_node = 2 * walk_node + 1 + int'(plru_arr[idx][walk_node]);
    end
  end

  assign victim_sel = inv_found ? inv_way : plru_way;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (req) state_next = CHECK;
      CHECK: begin
        if (!req)    state_next = IDLE;
        else if (hit) state_next = IDLE;
        else if (valid_arr[idx][victim_sel] && dirty_arr[idx][victim_sel]) state_next = WB;
        else         state_next = FILL;
      end
      WB:    if (bus.pmem_resp) state_next = FILL;
      FILL:  if (bus.pmem_resp) state_next = CHECK;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = data_arr[idx][hit_way];
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = data_arr[idx][victim_q];
    case (state)
      CHECK: bus.mem_resp = req & hit;
      WB: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_arr[idx][victim_q], idx, {s_offset{1'b0}}};
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {tag, idx, {s_offset{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CHECK && !hit) victim_q <= victim_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      case (state)
        CHECK: if (req && hit) begin
          plru_arr[idx] <= plru_touch(plru_arr[idx], hit_way);
          if (wr) dirty_arr[idx][hit_way] <= 1'b1;
        end
        WB:   if (bus.pmem_resp) dirty_arr[idx][victim_q] <= 1'b0;
        FILL: if (bus.pmem_resp) begin
          valid_arr[idx][victim_q] <= 1'b1;
          dirty_arr[idx][victim_q] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line and tag storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CHECK && req && hit && wr)
        data_arr[idx][hit_way] <= merge(data_arr[idx][hit_way], bus.mem_wdata, bus.mem_byte_enable);
      if (state == FILL && bus.pmem_resp) begin
        data_arr[idx][victim_q] <= bus.pmem_rdata;
        tag_arr[idx][victim_q]  <= tag;
      end
    end
  end
endmodule

// File: doc/l2_cache_nway.md
Name: l2_cache_nway

Overview:
- Parametrised write-back, write-allocate, N-way set-associative line cache.
- Sits between the L1/arbiter side (256-bit line port) and the cacheline adapter (256-bit pmem port).
- Next generation of the 2-way L2: way count and set count are generic, replacement is tree pseudo-LRU, and write byte-enables cover the full line.
- Tag, valid, dirty, PLRU and data arrays plus the controller live in one module.

Parameters:
- s_offset, 5, byte-offset bits; line = 2**s_offset bytes, fixed at 32 (256 bits).
- s_index, 3, set-index bits; num_sets = 2**s_index.
- num_ways, 4, associativity; power of two, 2..8.
- s_tag, 32-s_offset-s_index, tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- mem_read  in  1  line read request; held until mem_resp.
- mem_write  in  1  line write request; held until mem_resp.
- mem_address  in  32  byte address; bits [4:0] ignored.
- mem_wdata  in  256  write line.
- mem_byte_enable  in  32  per-byte write mask, bit i -> byte i.
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  256  line data, valid when mem_resp=1.
- pmem_resp  in  1  adapter completion.
- pmem_rdata  in  256  fill data, valid with pmem_resp.
- pmem_read  out  1  fill request.
- pmem_write  out  1  writeback request.
- pmem_address  out  32  line-aligned address, [4:0]=0.
- pmem_wdata  out  256  victim line.

Behaviour:
- Reset: clk is the single clock; rst is synchronous, active-high. When rst=1 at an edge:
  - all valid, dirty and PLRU bits clear; state goes to IDLE;
  - next cycle mem_resp, pmem_read and pmem_write are 0;
  - pmem_address and mem_rdata are don't-care.
  - A reset during WB/FILL abandons the transaction; data arrays are not cleared.
- States: IDLE, CHECK, WB, FILL.
- IDLE: any mem_read|mem_write -> CHECK. Both set -> treated as a write.
- CHECK: compare the tag against all num_ways ways of the set.
  - Hit: combinational mem_resp=1 this cycle; mem_rdata = hit-way line (pre-write value on writes).
  - Write hit: bytes with enable=1 take mem_wdata, others are kept; dirty=1.
  - Every hit updates PLRU so the tree points away from the hit way. -> IDLE.
  - Hit latency is 2 cycles from request assertion, with mem_resp in the 2nd cycle.
- Miss victim selection:
  - lowest-index invalid way; otherwise the PLRU victim.
  - Victim is latched in CHECK and held through WB/FILL.
  - Victim valid&dirty -> WB; otherwise -> FILL.
- WB:
  - pmem_write=1; pmem_address={victim tag, index, 5'b0}; pmem_wdata=victim line.
  - Held stable until pmem_resp. On pmem_resp: clear dirty -> FILL.
- FILL:
  - pmem_read=1; pmem_address={req tag, index, 5'b0}.
  - On pmem_resp: write pmem_rdata into the victim way; tag=req tag, valid=1, dirty=0 -> CHECK, which then hits.
  - Miss latency = 2 + WB time + FILL time + 1 cycles.
- pmem_read and pmem_write are never both 1. mem_resp is never 1 outside CHECK.
- PLRU is a binary tree of num_ways-1 bits per set.
  - Read: follow bits (0=left, 1=right) to the victim.
  - Update: set each bit on the path to point away from the accessed way.
- Requester must hold address, data and enables stable until mem_resp. Deasserting early is undefined.
- mem_byte_enable=0 on a write hit: no data change, but dirty is still set.

Test Plan:
- Reset, then read 0x0000_0040 -> pmem_read with pmem_address=0x0000_0040; after pmem_resp with line L, mem_resp one cycle later with mem_rdata=L, pmem_write never asserted.
- Repeat read 0x0000_0040 -> mem_resp in 2nd cycle, no pmem activity.
- Write 0x0000_0040, wdata all 0xFF, byte_enable=0x0000_000F, then read -> bytes 0-3 = 0xFF, bytes 4-31 = L.
- Fill 4 distinct tags into set 2 (0x040, 0x140, 0x240, 0x340), then access 0x040, 0x240, then miss on 0x440 -> victim is the PLRU-selected way (0x140's way); no WB if clean.
- Dirty line 0x040 evicted by a conflicting miss -> pmem_write first with pmem_address=0x0000_0040 and the modified line, then pmem_read for the new tag.
- Assert rst during FILL -> pmem_read=0 next cycle, mem_resp=0; a subsequent read of the same address misses again.
